mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 100 ++++++++++
 tb/tb_mem_access_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding CPU load/store unit with sub-word read-modify-write over a word memory
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, RDATA, WR, RESP} state_t;
  state_t state, nxt;
  logic wr_q, sgn_q;
  logic [1:0] size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, shifted, lane_mask, merged, load_data;
  logic [4:0] sh;
  logic accept, req_err;
  assign accept = req_valid && req_ready;
  assign req_err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign sh = {addr_q[1:0], 3'b000};
  assign shifted = mem_rdata >> sh;
  assign lane_mask = (size_q == 2'b00 ? DATA_W'(8'hFF) : DATA_W'(16'hFFFF)) << sh;
  assign merged = (mem_rdata & ~lane_mask) | ((wdata_q << sh) & lane_mask);
  assign load_data = size_q == 2'b00 ? {{(DATA_W-8){sgn_q & shifted[7]}}, shifted[7:0]} :
                     size_q == 2'b01 ? {{(DATA_W-16){sgn_q & shifted[15]}}, shifted[15:0]} :
                     shifted;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  // next state: errors skip memory, word stores skip the read, sub-word stores read then write
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = req_err ? RESP : (req_write && req_size == 2'b10) ? WR : RD;
      RD:      nxt = RDATA;
      RDATA:   nxt = wr_q ? WR : RESP;
      WR:      nxt = RESP;
      RESP:    if (resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // memory-side and request-side outputs decoded from state
  always_comb begin
    req_ready = state == IDLE;
    mem_we    = state == WR;
    mem_addr  = (state == RD || state == WR) ? addr_q >> 2 : '0;
    mem_wdata = state == WR ? wdata_q : '0;
  end
  // request capture; sub-word stores fold the read word into wdata_q before WR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= req_write;
      sgn_q   <= req_signed;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state == RDATA && wr_q) begin
      wdata_q <= merged;
    end
  end
  // response registers load on entry to RESP and hold until the CPU takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else if (state != RESP && nxt == RESP) begin
      resp_valid <= 1'b1;
      resp_err   <= state == IDLE;
      resp_rdata <= (state == RDATA && !wr_q) ? load_data : '0;
    end else if (state == RESP && resp_ready) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized self-checking bench against a word-array reference model
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, resp_ready = 1'b1;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:63] = '{default: '0};
  logic [31:0] refm [0:63];
  int total = 0, bad = 0, we_count = 0;
  logic [31:0] last_wdata = '0, last_waddr = '0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
      we_count <= we_count + 1;
      last_wdata <= mem_wdata;
      last_waddr <= mem_addr;
    end
    mem_rdata <= mem[mem_addr[5:0]];
  end

  task automatic exec_txn(input string name, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
    logic [31:0] word, v, mask, exp_rd;
    logic exp_er;
    int off, idx, exp_lat, exp_we, lat, we0;
    idx = int'(a / 4) % 64;
    off = int'(a % 4);
    word = refm[idx];
    exp_er = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    exp_rd = 0;
    exp_we = 0;
    if (exp_er) exp_lat = 1;
    else if (!w) begin
      exp_lat = 3;
      v = word >> (8 * off);
      if (sz == 0) begin
        exp_rd = v & 32'hFF;
        if (sg && exp_rd >= 128) exp_rd = exp_rd + 32'hFFFF_FF00;
      end else if (sz == 1) begin
        exp_rd = v & 32'hFFFF;
        if (sg && exp_rd >= 32768) exp_rd = exp_rd + 32'hFFFF_0000;
      end else exp_rd = word;
    end else begin
      exp_we = 1;
      exp_lat = (sz == 2) ? 2 : 4;
      if (sz == 2) refm[idx] = wd;
      else begin
        mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
        refm[idx] = (word & ~mask) | ((wd << (8 * off)) & mask);
      end
    end
    we0 = we_count;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle: got %b want 1", name, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL %s ready_busy: got %b want 0", name, req_ready); end
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    total++;
    if (lat != exp_lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat); end
    total++;
    if (resp_rdata !== exp_rd) begin bad++; $display("FAIL %s rdata: got %h want %h", name, resp_rdata, exp_rd); end
    total++;
    if (resp_err !== exp_er) begin bad++; $display("FAIL %s err: got %b want %b", name, resp_err, exp_er); end
    @(posedge clk); #1;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL %s retire: got valid=%b ready=%b want valid=0 ready=1", name, resp_valid, req_ready);
    end
    total++;
    if (we_count - we0 != exp_we) begin bad++; $display("FAIL %s we_pulses: got %0d want %0d", name, we_count - we0, exp_we); end
    total++;
    if (mem[idx] !== refm[idx]) begin bad++; $display("FAIL %s mem_word: got %h want %h", name, mem[idx], refm[idx]); end
    if (exp_we == 1) begin
      total++;
      if (last_waddr !== 32'(idx)) begin bad++; $display("FAIL %s waddr: got %h want %h", name, last_waddr, idx); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
        mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: got ready=%b valid=%b err=%b rdata=%h we=%b addr=%h wdata=%h want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    logic er;
    exec_txn("st_word", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er);
    total++;
    if (last_waddr !== 32'h4) begin bad++; $display("FAIL st_word_addr: got %h want 4", last_waddr); end
    exec_txn("ld_word", 0, 2'b10, 0, 32'h10, 32'h0, rd, er);
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL ld_word_val: got %h/%b want deadbeef/0", rd, er); end
    exec_txn("preset_rmw", 1, 2'b10, 0, 32'h10, 32'h11223344, rd, er);
    exec_txn("st_byte", 1, 2'b00, 0, 32'h11, 32'hAA, rd, er);
    total++;
    if (last_wdata !== 32'h1122AA44) begin bad++; $display("FAIL st_byte_merge: got %h want 1122aa44", last_wdata); end
    exec_txn("preset_ext", 1, 2'b10, 0, 32'h10, 32'h8000F0FF, rd, er);
    exec_txn("ld_sbyte", 0, 2'b00, 1, 32'h10, 32'h0, rd, er);
    total++;
    if (rd !== 32'hFFFFFFFF) begin bad++; $display("FAIL ld_sbyte_val: got %h want ffffffff", rd); end
    exec_txn("ld_uhalf", 0, 2'b01, 0, 32'h12, 32'h0, rd, er);
    total++;
    if (rd !== 32'h00008000) begin bad++; $display("FAIL ld_uhalf_val: got %h want 00008000", rd); end
    exec_txn("ld_shalf", 0, 2'b01, 1, 32'h12, 32'h0, rd, er);
    total++;
    if (rd !== 32'hFFFF8000) begin bad++; $display("FAIL ld_shalf_val: got %h want ffff8000", rd); end
    exec_txn("err_half", 0, 2'b01, 0, 32'h13, 32'h0, rd, er);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_half_val: got %h/%b want 0/1", rd, er); end
    exec_txn("err_word", 1, 2'b10, 0, 32'h12, 32'h12345678, rd, er);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_word_val: got %h/%b want 0/1", rd, er); end
    exec_txn("err_size", 1, 2'b11, 0, 32'h10, 32'h12345678, rd, er);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_size_val: got %h/%b want 0/1", rd, er); end
  endtask

  task automatic test_stall();
    logic [31:0] rd, exp;
    logic er;
    int lat;
    exec_txn("stall_preset", 1, 2'b10, 0, 32'h40, 32'hCAFE0123, rd, er);
    exp = refm[16];
    @(negedge clk);
    resp_ready = 1'b0;
    req_write = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h40; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat != 3) begin bad++; $display("FAIL stall_latency: got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: got valid=%b rdata=%h ready=%b want 1 %h 0", resp_valid, resp_rdata, req_ready, exp);
      end
      @(posedge clk); #1;
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL stall_retire: got valid=%b ready=%b want 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er;
    int we0;
    exec_txn("rst_preset", 1, 2'b10, 0, 32'h20, 32'h55667788, rd, er);
    we0 = we_count;
    @(negedge clk);
    req_write = 1; req_size = 2'b00; req_signed = 0; req_addr = 32'h21; req_wdata = 32'hEE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
        mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got ready=%b valid=%b err=%b rdata=%h we=%b addr=%h wdata=%h want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata);
    end
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b0 || mem_we !== 1'b0) begin
        bad++; $display("FAIL mid_reset_quiet: got valid=%b we=%b want 0 0", resp_valid, mem_we);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (we_count != we0 || mem[8] !== refm[8]) begin
      bad++; $display("FAIL mid_reset_dropped: got pulses=%0d word=%h want 0 %h", we_count - we0, mem[8], refm[8]);
    end
    exec_txn("after_reset_st", 1, 2'b00, 0, 32'h22, 32'h99, rd, er);
    exec_txn("after_reset_ld", 0, 2'b10, 0, 32'h20, 32'h0, rd, er);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 80; i++)
      exec_txn("random", 1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 255)), $urandom, rd, er);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) refm[i] = '0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
